// File: rtl/regularni_pkg.sv
// Shared encodings for the regular NI FIFO read controller.
package regularni_pkg;

  // Word type codes carried in word[15:13] by the write controller
  localparam logic [2:0] WTYPE_HEAD = 3'b000;
  localparam logic [2:0] WTYPE_BODY = 3'b110;

  // Flit type codes placed in flit_out[17:16]
  localparam logic [1:0] FTYPE_HEAD = 2'b10;
  localparam logic [1:0] FTYPE_BODY = 2'b00;
  localparam logic [1:0] FTYPE_TAIL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } rd_state_t;

endpackage

// File: rtl/regularni_credit_counter.sv
// Credit counter toward the router input buffer: starts full at CREDITS,
// -1 per flit sent, +1 per returned credit, saturates at CREDITS.
module regularni_credit_counter #(
  parameter int unsigned CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] credit_cnt,
  output logic       credit_ovf
);

  localparam logic [3:0] CMAX = 4'(CREDITS);

  // Credit count register; simultaneous inc and dec cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CMAX;
    end else if (dec && !inc) begin
      credit_cnt <= credit_cnt - 4'd1;
    end else if (inc && !dec && (credit_cnt != CMAX)) begin
      credit_cnt <= credit_cnt + 4'd1;
    end
  end

  // Returned credit with no room to hold it
  always_comb begin
    credit_ovf = !rst && inc && !dec && (credit_cnt == CMAX);
  end

endmodule

// File: rtl/regularni_fifo_rdctrl.sv
// Drain side of the regular NI FIFO: pops words, checks head/body framing,
// and sends flits to the router local port under credit flow control.
// Optional packet/drop statistics enabled by defining REGULARNI_PKT_STATS_EN.
module regularni_fifo_rdctrl
  import regularni_pkg::*;
#(
  parameter int unsigned PKT_LEN = 1,
  parameter int unsigned CREDITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_rd,
  output logic        flit_valid,
  output logic [17:0] flit_out,
  output logic [3:0]  flit_dest,
  input  logic        credit_in,
  output logic        err_drop,
  output logic        credit_ovf,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [3:0] PKT_LEN_4 = 4'(PKT_LEN);

  rd_state_t  state, state_nx;
  logic [3:0] body_cnt;
  logic [3:0] credit_cnt;
  logic       send;
  logic       word_ok;
  logic [1:0] ftype_nx;

  regularni_credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk        (clk),
    .rst        (rst),
    .inc        (credit_in),
    .dec        (send),
    .credit_cnt (credit_cnt),
    .credit_ovf (credit_ovf)
  );

  // Framing check: expected word type depends on position within the packet
  always_comb begin
    word_ok  = 1'b0;
    ftype_nx = FTYPE_HEAD;
    if (body_cnt == 4'd0) begin
      word_ok  = (fifo_data[15:13] == WTYPE_HEAD);
      ftype_nx = FTYPE_HEAD;
    end else begin
      word_ok  = (fifo_data[15:13] == WTYPE_BODY);
      ftype_nx = (body_cnt == PKT_LEN_4) ? FTYPE_TAIL : FTYPE_BODY;
    end
  end

  // Next state and strobes; SEND may prefetch the next word when a credit
  // will still be left after this flit (or one is returning this cycle)
  always_comb begin
    state_nx   = state;
    fifo_rd    = 1'b0;
    flit_valid = 1'b0;
    err_drop   = 1'b0;
    send       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst && enable && !fifo_empty && (credit_cnt != 4'd0)) begin
          fifo_rd  = 1'b1;
          state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (word_ok) begin
          state_nx = ST_SEND;
        end else begin
          err_drop = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_SEND: begin
        flit_valid = 1'b1;
        send       = 1'b1;
        if (enable && !fifo_empty && ((credit_cnt >= 4'd2) || credit_in)) begin
          fifo_rd  = 1'b1;
          state_nx = ST_LOAD;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Flit and destination registers, loaded on an accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_out  <= '0;
      flit_dest <= '0;
    end else if ((state == ST_LOAD) && word_ok) begin
      flit_out <= {ftype_nx, fifo_data};
      if (body_cnt == 4'd0) flit_dest <= fifo_data[7:4];
    end
  end

  // Position within packet; advances only when a flit actually leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      body_cnt <= '0;
    end else if (send) begin
      body_cnt <= (body_cnt == PKT_LEN_4) ? 4'd0 : body_cnt + 4'd1;
    end
  end

`ifdef REGULARNI_PKT_STATS_EN
  logic tail_sent;
  assign tail_sent = send && (flit_out[17:16] == FTYPE_TAIL);

  // Saturating packet and drop statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (tail_sent && (pkt_cnt != '1)) pkt_cnt  <= pkt_cnt + 16'd1;
      if (err_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_regularni_fifo_rdctrl.sv
// Directed bench for regularni_fifo_rdctrl (PKT_LEN=1, CREDITS=4).
module tb_regularni_fifo_rdctrl;

`ifdef REGULARNI_PKT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd;
  logic        flit_valid;
  logic [17:0] flit_out;
  logic [3:0]  flit_dest;
  logic        credit_in;
  logic        err_drop;
  logic        credit_ovf;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  int nflit    = 0;
  int ndrop    = 0;
  int rd_empty_viol = 0;
  int d0;

  logic [15:0] fifo_q[$];
  logic [17:0] exp_q[$];

  regularni_fifo_rdctrl #(.PKT_LEN(1), .CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .flit_valid (flit_valid),
    .flit_out   (flit_out),
    .flit_dest  (flit_dest),
    .credit_in  (credit_in),
    .err_drop   (err_drop),
    .credit_ovf (credit_ovf),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fifo_q.size() == 0);

  // Registered FIFO model: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fifo_q.size() == 0) rd_empty_viol++;
      else fifo_data <= fifo_q.pop_front();
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sampling on the falling edge; every flit seen is
  // checked against the expected queue in order
  task automatic step();
    @(negedge clk);
    if (flit_valid) begin
      nflit++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_flit observed=%h expected=none", flit_out);
      end
      if (exp_q.size() != 0) check("flit_out", 32'(flit_out), 32'(exp_q.pop_front()));
    end
    if (err_drop) ndrop++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic give_credit();
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; credit_in = 1'b0; fifo_data = '0;
    steps(2);
    rst = 1'b0;
    step();

    // Reset state
    check("rst_fifo_rd",    32'(fifo_rd),    0);
    check("rst_flit_valid", 32'(flit_valid), 0);
    check("rst_flit_out",   32'(flit_out),   0);
    check("rst_flit_dest",  32'(flit_dest),  0);
    check("rst_credit_cnt", 32'(dut.credit_cnt), 4);
    check("rst_err_drop",   32'(err_drop),   0);
    check("rst_pkt_cnt",    32'(pkt_cnt),    0);

    // Head + tail, exact latency
    enable = 1'b1;
    push(16'h0035); push(16'hC007);
    exp_q.push_back(18'h20035); exp_q.push_back(18'h1C007);
    #1;
    check("t2_rd_t0", 32'(fifo_rd), 1);
    step();
    check("t2_valid_t1", 32'(flit_valid), 0);
    step();
    check("t2_valid_t2", 32'(flit_valid), 1);
    check("t2_dest", 32'(flit_dest), 3);
    check("t2_prefetch", 32'(fifo_rd), 1);
    step();
    check("t2_valid_t3", 32'(flit_valid), 0);
    step();
    check("t2_valid_t4", 32'(flit_valid), 1);
    check("t2_credit_mid", 32'(dut.credit_cnt), 3);
    step();
    check("t2_credit_end", 32'(dut.credit_cnt), 2);
    check("t2_pkt_cnt", 32'(pkt_cnt), 32'(STATS));
    check("t2_exp_drained", 32'(exp_q.size()), 0);

    // Reset mid-packet: head sent, tail pending
    push(16'h0044);
    exp_q.push_back(18'h20044);
    for (int i = 0; i < 8 && !flit_valid; i++) step();
    check("t6_head_seen", 32'(flit_valid), 1);
    step();
    check("t6_credit_before", 32'(dut.credit_cnt), 1);
    check("t6_body_cnt_before", 32'(dut.body_cnt), 1);
    push(16'hC005);
    #1;
    check("t6_rd_before_rst", 32'(fifo_rd), 1);
    rst = 1'b1;
    #1;
    check("t1_fifo_rd",    32'(fifo_rd),    0);
    check("t1_flit_valid", 32'(flit_valid), 0);
    check("t1_flit_out",   32'(flit_out),   0);
    check("t1_flit_dest",  32'(flit_dest),  0);
    check("t1_credit_cnt", 32'(dut.credit_cnt), 4);
    check("t1_err_drop",   32'(err_drop),   0);
    check("t1_body_cnt",   32'(dut.body_cnt), 0);
    check("t1_pkt_cnt",    32'(pkt_cnt),    0);
    steps(2);
    rst = 1'b0;
    d0 = ndrop;
    push(16'h0021); push(16'hC021);
    exp_q.push_back(18'h20021); exp_q.push_back(18'h1C021);
    steps(12);
    check("t6_drop", 32'(ndrop), 32'(d0 + 1));
    check("t6_exp_drained", 32'(exp_q.size()), 0);
    check("t6_dest", 32'(flit_dest), 2);
    check("t6_drop_cnt", 32'(drop_cnt), 32'(STATS));
    check("t6_pkt_cnt", 32'(pkt_cnt), 32'(STATS));
    check("t6_credit", 32'(dut.credit_cnt), 2);

    // Credit return and overflow on an idle link
    give_credit();
    give_credit();
    check("t5_credit_full", 32'(dut.credit_cnt), 4);
    credit_in = 1'b1;
    #1;
    check("t5_ovf_pulse", 32'(credit_ovf), 1);
    step();
    credit_in = 1'b0;
    #1;
    check("t5_ovf_clear", 32'(credit_ovf), 0);
    check("t5_ovf_hold", 32'(dut.credit_cnt), 4);

    // Credit return coincident with a send
    push(16'h0010); push(16'hC0AA);
    exp_q.push_back(18'h20010); exp_q.push_back(18'h1C0AA);
    for (int i = 0; i < 8 && !flit_valid; i++) step();
    check("t5_head_seen", 32'(flit_valid), 1);
    credit_in = 1'b1;
    #1;
    check("t5_no_ovf_on_send", 32'(credit_ovf), 0);
    step();
    credit_in = 1'b0;
    check("t5_credit_same", 32'(dut.credit_cnt), 4);
    steps(4);
    check("t5_credit_after_tail", 32'(dut.credit_cnt), 3);
    give_credit();

    // Enable low blocks pops; bad head dropped, next head accepted
    enable = 1'b0;
    d0 = ndrop;
    push(16'hC001); push(16'h0012); push(16'hC012);
    exp_q.push_back(18'h20012); exp_q.push_back(18'h1C012);
    steps(4);
    check("t4_disabled_rd", 32'(fifo_rd), 0);
    check("t4_disabled_fifo", 32'(fifo_q.size()), 3);
    enable = 1'b1;
    steps(12);
    check("t4_drop", 32'(ndrop), 32'(d0 + 1));
    check("t4_exp_drained", 32'(exp_q.size()), 0);
    check("t4_dest", 32'(flit_dest), 1);
    check("t4_drop_cnt", 32'(drop_cnt), 32'(2 * STATS));
    give_credit();
    give_credit();

    // Credit exhaustion: 6 words, only 4 flits until credits return
    push(16'h0011); push(16'hC001); push(16'h0022);
    push(16'hC002); push(16'h0033); push(16'hC003);
    exp_q.push_back(18'h20011); exp_q.push_back(18'h1C001);
    exp_q.push_back(18'h20022); exp_q.push_back(18'h1C002);
    exp_q.push_back(18'h20033); exp_q.push_back(18'h1C003);
    steps(20);
    check("t3_four_flits", 32'(exp_q.size()), 2);
    check("t3_credit_zero", 32'(dut.credit_cnt), 0);
    check("t3_stall_rd", 32'(fifo_rd), 0);
    check("t3_fifo_left", 32'(fifo_q.size()), 2);
    give_credit();
    for (int i = 0; i < 2 && exp_q.size() != 1; i++) step();
    check("t3_fifth_flit", 32'(exp_q.size()), 1);
    for (int i = 0; i < 5; i++) give_credit();
    steps(6);
    check("t3_exp_drained", 32'(exp_q.size()), 0);
    check("t3_credit_restored", 32'(dut.credit_cnt), 4);
    check("end_pkt_cnt", 32'(pkt_cnt), 32'(6 * STATS));
    check("end_drop_cnt", 32'(drop_cnt), 32'(2 * STATS));
    check("rd_while_empty", 32'(rd_empty_viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
